board_mem_arbiter: RTL and testbench

- Owns the tile-matching board storage: NUM_TILES entries, each a tile value plus a matched flag.
- On start it fills the board with value pairs, then shuffles it with a free-running LFSR.
- Afterwards it arbitrates the single storage port between the in-game FSM (read/write) and the display scanner (read-only, future VGA drawer).
- Sits between the game-mode/in-game FSMs and the display path.

---
 rtl/board_pkg.sv | 40 ++++
 rtl/lfsr8.sv | 22 ++
 rtl/board_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_board_mem_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// board_pkg: shared definitions for the tile-matching board storage.
// Holds the default board geometry, the tile entry layout {matched, value},
// the board controller state encoding, the LFSR seed, and the helper that
// folds a raw LFSR nibble onto a valid tile index.
package board_pkg;

    localparam int NUM_TILES  = 10;
    localparam int VAL_W      = 3;
    localparam int ENTRY_W    = VAL_W + 1;
    localparam int INIT_SWAPS = 16;
    localparam int ADDR_W     = 4;
    localparam int LFSR_W     = 8;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

    typedef struct packed {
        logic             matched;
        logic [VAL_W-1:0] value;
    } tile_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_SHUFFLE = 2'd2,
        ST_READY   = 2'd3
    } state_t;

    // Map a 4-bit random value onto [0, n): subtract n once, and if the
    // result is still out of range fall back to entry 0.
    function automatic logic [ADDR_W-1:0] fold_index(
        input logic [ADDR_W-1:0] raw,
        input logic [ADDR_W:0]   n
    );
        logic [ADDR_W-1:0] r;
        r = raw;
        if ({1'b0, r} >= n) r = r - n[ADDR_W-1:0];
        if ({1'b0, r} >= n) r = '0;
        return r;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8: free-running 8-bit Fibonacci LFSR, taps 8,6,5,4.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, loads SEED
//   value - current LFSR state
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= SEED;
        end else begin
            value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
        end
    end

endmodule

// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter: owns the tile-matching board. On start it fills the
// board with value pairs, shuffles it with a free-running LFSR, then shares
// the single storage port between the game FSM (read/write) and the display
// scanner (read-only).
// Ports:
//   CLOCK_50                 - system clock
//   userquit                 - synchronous active-high reset
//   start                    - one-cycle pulse, begin a new board
//   init_done                - high while the board is ready
//   game_req/we/addr/wdata   - game access request
//   game_gnt                 - game access accepted this cycle
//   game_rvalid/rdata        - game read return, one cycle after grant
//   disp_req/addr            - display read request
//   disp_gnt                 - display access accepted this cycle
//   disp_rvalid/rdata        - display read return, one cycle after grant
module board_mem_arbiter
    import board_pkg::*;
#(
    parameter int         NUM_TILES  = board_pkg::NUM_TILES,
    parameter int         VAL_W      = board_pkg::VAL_W,
    parameter int         INIT_SWAPS = board_pkg::INIT_SWAPS,
    parameter logic [7:0] LFSR_SEED  = board_pkg::LFSR_SEED
) (
    input  logic             CLOCK_50,
    input  logic             userquit,
    input  logic             start,
    output logic             init_done,
    input  logic             game_req,
    input  logic             game_we,
    input  logic [3:0]       game_addr,
    input  logic [VAL_W:0]   game_wdata,
    output logic             game_gnt,
    output logic             game_rvalid,
    output logic [VAL_W:0]   game_rdata,
    input  logic             disp_req,
    input  logic [3:0]       disp_addr,
    output logic             disp_gnt,
    output logic             disp_rvalid,
    output logic [VAL_W:0]   disp_rdata
);

    localparam int TILE_W = VAL_W + 1;
    localparam int SWAP_W = $clog2(INIT_SWAPS + 1);
    localparam logic [ADDR_W:0]   TILES_X   = (ADDR_W + 1)'(NUM_TILES);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_TILES - 1);
    localparam logic [SWAP_W-1:0] LAST_SWAP = SWAP_W'(INIT_SWAPS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [SWAP_W-1:0]   cnt_q, cnt_d;
    logic                fill_we;
    logic                swap_en;
    logic [7:0]          lfsr_q;
    logic [ADDR_W-1:0]   swap_j;
    logic                unused_lfsr_hi;

    logic [TILE_W-1:0]   board [NUM_TILES];

    logic                is_ready;
    logic                disp_denied_q;
    logic                game_in_range, disp_in_range;
    logic                game_rd_en, game_wr_en, disp_rd_en;
    logic [TILE_W-1:0]   game_rd_val, disp_rd_val;

    logic                game_rvld_p1, disp_rvld_p1;
    logic [TILE_W-1:0]   game_rdata_p1, disp_rdata_p1;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (CLOCK_50),
        .rst   (userquit),
        .value (lfsr_q)
    );

    // Only the low nibble picks the swap partner.
    assign unused_lfsr_hi = ^lfsr_q[7:4];
    assign swap_j         = fold_index(lfsr_q[3:0], TILES_X);

    // ---------------- controller ----------------
    always_ff @(posedge CLOCK_50) begin
        if (userquit) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // idx_q is the fill index in FILL and the swap slot k in SHUFFLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        fill_we = 1'b0;
        swap_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FILL;
                    idx_d   = '0;
                end
            end
            ST_FILL: begin
                fill_we = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_SHUFFLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_SHUFFLE: begin
                swap_en = 1'b1;
                idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_SWAP) state_d = ST_READY;
            end
            ST_READY: begin
                if (start) begin
                    state_d = ST_FILL;
                    idx_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- arbitration ----------------
    // Game wins by default; a display request denied last cycle wins now,
    // so the display never waits more than one cycle.
    assign is_ready  = (state_q == ST_READY);
    assign init_done = is_ready;
    assign game_gnt  = is_ready && game_req && !(disp_req && disp_denied_q);
    assign disp_gnt  = is_ready && disp_req && !game_gnt;

    always_ff @(posedge CLOCK_50) begin
        if (userquit) disp_denied_q <= 1'b0;
        else          disp_denied_q <= disp_req && !disp_gnt;
    end

    assign game_in_range = ({1'b0, game_addr} < TILES_X);
    assign disp_in_range = ({1'b0, disp_addr} < TILES_X);
    assign game_rd_en    = game_gnt && !game_we;
    assign game_wr_en    = game_gnt && game_we && game_in_range;
    assign disp_rd_en    = disp_gnt;
    assign game_rd_val   = game_in_range ? board[game_addr] : '0;
    assign disp_rd_val   = disp_in_range ? board[disp_addr] : '0;

    // ---------------- storage ----------------
    // FILL, SHUFFLE and game writes are state-exclusive.
    always_ff @(posedge CLOCK_50) begin
        if (userquit) begin
            for (int i = 0; i < NUM_TILES; i++) board[i] <= '0;
        end else if (fill_we) begin
            board[idx_q] <= {1'b0, VAL_W'(idx_q >> 1)};
        end else if (swap_en) begin
            if (swap_j != idx_q) begin
                board[idx_q]  <= board[swap_j];
                board[swap_j] <= board[idx_q];
            end
        end else if (game_wr_en) begin
            board[game_addr] <= game_wdata;
        end
    end

    // ---------------- stage p1: read return ----------------
    always_ff @(posedge CLOCK_50) begin
        if (userquit) begin
            game_rvld_p1  <= 1'b0;
            disp_rvld_p1  <= 1'b0;
            game_rdata_p1 <= '0;
            disp_rdata_p1 <= '0;
        end else begin
            game_rvld_p1 <= game_rd_en;
            disp_rvld_p1 <= disp_rd_en;
            if (game_rd_en) game_rdata_p1 <= game_rd_val;
            if (disp_rd_en) disp_rdata_p1 <= disp_rd_val;
        end
    end

    assign game_rvalid = game_rvld_p1;
    assign game_rdata  = game_rdata_p1;
    assign disp_rvalid = disp_rvld_p1;
    assign disp_rdata  = disp_rdata_p1;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Testbench for board_mem_arbiter: a reference model of fill + LFSR shuffle
// predicts the board; expected read data is queued when a request is driven
// and compared when the read returns.
module tb_board_mem_arbiter;

    localparam int N = 10;

    logic       CLOCK_50 = 1'b0;
    logic       userquit = 1'b1;
    logic       start = 1'b0;
    logic       init_done;
    logic       game_req = 1'b0;
    logic       game_we = 1'b0;
    logic [3:0] game_addr = '0;
    logic [3:0] game_wdata = '0;
    logic       game_gnt;
    logic       game_rvalid;
    logic [3:0] game_rdata;
    logic       disp_req = 1'b0;
    logic [3:0] disp_addr = '0;
    logic       disp_gnt;
    logic       disp_rvalid;
    logic [3:0] disp_rdata;

    int checks = 0;
    int errors = 0;

    logic [3:0] model [16];
    logic [3:0] gq [$];
    logic [3:0] dq [$];
    logic [7:0] m_lfsr;

    board_mem_arbiter dut (
        .CLOCK_50    (CLOCK_50),
        .userquit    (userquit),
        .start       (start),
        .init_done   (init_done),
        .game_req    (game_req),
        .game_we     (game_we),
        .game_addr   (game_addr),
        .game_wdata  (game_wdata),
        .game_gnt    (game_gnt),
        .game_rvalid (game_rvalid),
        .game_rdata  (game_rdata),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_gnt    (disp_gnt),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    always @(posedge CLOCK_50) begin
        if (userquit) m_lfsr <= 8'hA5;
        else          m_lfsr <= lfsr_next(m_lfsr);
    end

    // l0 is the LFSR value in the cycle where start is sampled; swap s uses
    // the value 11+s edges later.
    task automatic build_model(input logic [7:0] l0);
        logic [7:0] l;
        logic [3:0] j;
        logic [3:0] t;
        int k;
        for (int i = 0; i < 16; i++) model[i] = 4'h0;
        for (int i = 0; i < N; i++) model[i] = {1'b0, 3'(i / 2)};
        l = l0;
        repeat (11) l = lfsr_next(l);
        for (int s = 0; s < 16; s++) begin
            j = l[3:0];
            if (j >= 4'(N)) j = j - 4'(N);
            if (j >= 4'(N)) j = 4'h0;
            k = s % N;
            t = model[k];
            model[k] = model[j];
            model[j] = t;
            l = lfsr_next(l);
        end
    endtask

    task automatic game_access(input logic we, input logic [3:0] addr, input logic [3:0] wdata,
                               output logic gnt, output logic rv, output logic [3:0] rd);
        int n;
        game_req = 1'b1; game_we = we; game_addr = addr; game_wdata = wdata;
        #1;
        n = 0;
        while (!game_gnt && n < 8) begin
            @(negedge CLOCK_50); #1; n++;
        end
        gnt = game_gnt;
        @(negedge CLOCK_50);
        rv = game_rvalid; rd = game_rdata;
        game_req = 1'b0; game_we = 1'b0;
    endtask

    task automatic disp_access(input logic [3:0] addr, output logic gnt, output logic rv, output logic [3:0] rd);
        int n;
        disp_req = 1'b1; disp_addr = addr;
        #1;
        n = 0;
        while (!disp_gnt && n < 8) begin
            @(negedge CLOCK_50); #1; n++;
        end
        gnt = disp_gnt;
        @(negedge CLOCK_50);
        rv = disp_rvalid; rd = disp_rdata;
        disp_req = 1'b0;
    endtask

    task automatic start_game();
        build_model(m_lfsr);
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    task automatic wait_init(output int cyc);
        cyc = 0;
        while (!init_done && cyc < 100) begin
            @(negedge CLOCK_50); cyc++;
        end
    endtask

    task automatic read_all_game(input string tag);
        logic g, rv;
        logic [3:0] rd, e;
        for (int a = 0; a < N; a++) begin
            gq.push_back(model[a]);
            game_access(1'b0, 4'(a), 4'h0, g, rv, rd);
            e = gq.pop_front();
            checks++;
            if (g !== 1'b1 || rv !== 1'b1 || rd !== e) begin
                errors++;
                $display("FAIL %s addr %0d: gnt %b rvalid %b rdata %h, expected 1 1 %h", tag, a, g, rv, rd, e);
            end
        end
    endtask

    task automatic test_reset();
        userquit = 1'b1; game_req = 1'b1; disp_req = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        #1;
        checks++;
        if ({init_done, game_gnt, disp_gnt, game_rvalid, disp_rvalid, game_rdata, disp_rdata} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {init_done, game_gnt, disp_gnt, game_rvalid, disp_rvalid, game_rdata, disp_rdata});
        end
        @(negedge CLOCK_50);
        userquit = 1'b0; game_req = 1'b0; disp_req = 1'b0;
        @(negedge CLOCK_50);
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_init_done: got %b expected 0", init_done);
        end
    endtask

    task automatic test_init();
        int cyc;
        int cnt [8];
        logic g, rv;
        logic [3:0] rd;
        start_game();
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL init_early: init_done %b expected 0", init_done);
        end
        wait_init(cyc);
        checks++;
        if (cyc != 26) begin
            errors++;
            $display("FAIL init_latency: got %0d cycles expected 26", cyc);
        end
        for (int v = 0; v < 8; v++) cnt[v] = 0;
        for (int a = 0; a < N; a++) begin
            gq.push_back(model[a]);
            game_access(1'b0, 4'(a), 4'h0, g, rv, rd);
            checks++;
            if (g !== 1'b1 || rv !== 1'b1 || rd !== gq.pop_front()) begin
                errors++;
                $display("FAIL init_read addr %0d: gnt %b rvalid %b rdata %h expected 1 1 %h", a, g, rv, rd, model[a]);
            end
            if (rd[3] === 1'b0) cnt[rd[2:0]]++;
        end
        for (int v = 0; v < 5; v++) begin
            checks++;
            if (cnt[v] != 2) begin
                errors++;
                $display("FAIL init_pairs value %0d: got %0d unmatched copies expected 2", v, cnt[v]);
            end
        end
    endtask

    task automatic test_write_read();
        logic g, rv;
        logic [3:0] rd, e;
        game_access(1'b1, 4'd3, 4'hE, g, rv, rd);
        checks++;
        if (g !== 1'b1 || rv !== 1'b0) begin
            errors++;
            $display("FAIL write_gnt: gnt %b rvalid %b expected 1 0", g, rv);
        end
        model[3] = 4'hE;
        gq.push_back(model[3]);
        game_access(1'b0, 4'd3, 4'h0, g, rv, rd);
        e = gq.pop_front();
        checks++;
        if (g !== 1'b1 || rv !== 1'b1 || rd !== e) begin
            errors++;
            $display("FAIL write_readback: gnt %b rvalid %b rdata %h expected 1 1 %h", g, rv, rd, e);
        end
        dq.push_back(model[3]);
        disp_access(4'd3, g, rv, rd);
        e = dq.pop_front();
        checks++;
        if (g !== 1'b1 || rv !== 1'b1 || rd !== e) begin
            errors++;
            $display("FAIL disp_readback: gnt %b rvalid %b rdata %h expected 1 1 %h", g, rv, rd, e);
        end
    endtask

    task automatic test_back_to_back();
        logic gg, dg;
        logic [3:0] e, last_d;
        last_d = 4'h0;
        for (int c = 0; c < 6; c++) begin
            game_req = 1'b1; game_we = 1'b0; game_addr = 4'(c);
            disp_req = 1'b1; disp_addr = 4'(9 - c);
            #1;
            gg = game_gnt; dg = disp_gnt;
            checks++;
            if ({gg, dg} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL alternate cycle %0d: gnt game/disp %b%b expected %b", c, gg, dg,
                         (c % 2 == 0) ? 2'b10 : 2'b01);
            end
            if (gg) gq.push_back(model[c]);
            if (dg) dq.push_back(model[9 - c]);
            @(negedge CLOCK_50);
            checks++;
            if ({game_rvalid, disp_rvalid} !== {gg, dg}) begin
                errors++;
                $display("FAIL alt_rvalid cycle %0d: rvalid game/disp %b%b expected %b%b", c, game_rvalid, disp_rvalid, gg, dg);
            end
            if (gg && gq.size() > 0) begin
                e = gq.pop_front();
                checks++;
                if (game_rdata !== e) begin
                    errors++;
                    $display("FAIL alt_game_rdata cycle %0d: got %h expected %h", c, game_rdata, e);
                end
            end
            if (dg && dq.size() > 0) begin
                e = dq.pop_front();
                last_d = e;
                checks++;
                if (disp_rdata !== e) begin
                    errors++;
                    $display("FAIL alt_disp_rdata cycle %0d: got %h expected %h", c, disp_rdata, e);
                end
            end
        end
        game_req = 1'b0; disp_req = 1'b0;
        @(negedge CLOCK_50);
        checks++;
        if (disp_rvalid !== 1'b0 || disp_rdata !== last_d) begin
            errors++;
            $display("FAIL rdata_hold: rvalid %b rdata %h expected 0 %h", disp_rvalid, disp_rdata, last_d);
        end
    endtask

    task automatic test_out_of_range();
        logic g, rv;
        logic [3:0] rd, e;
        gq.push_back(4'h0);
        game_access(1'b0, 4'd12, 4'h0, g, rv, rd);
        e = gq.pop_front();
        checks++;
        if (g !== 1'b1 || rv !== 1'b1 || rd !== e) begin
            errors++;
            $display("FAIL oob_read: gnt %b rvalid %b rdata %h expected 1 1 %h", g, rv, rd, e);
        end
        game_access(1'b1, 4'd15, 4'hF, g, rv, rd);
        checks++;
        if (g !== 1'b1 || rv !== 1'b0) begin
            errors++;
            $display("FAIL oob_write: gnt %b rvalid %b expected 1 0", g, rv);
        end
        for (int a = 0; a < N; a++) begin
            dq.push_back(model[a]);
            disp_access(4'(a), g, rv, rd);
            e = dq.pop_front();
            checks++;
            if (g !== 1'b1 || rv !== 1'b1 || rd !== e) begin
                errors++;
                $display("FAIL oob_board addr %0d: gnt %b rvalid %b rdata %h expected 1 1 %h", a, g, rv, rd, e);
            end
        end
        dq.push_back(4'h0);
        disp_access(4'd13, g, rv, rd);
        e = dq.pop_front();
        checks++;
        if (g !== 1'b1 || rv !== 1'b1 || rd !== e) begin
            errors++;
            $display("FAIL oob_disp_read: gnt %b rvalid %b rdata %h expected 1 1 %h", g, rv, rd, e);
        end
    endtask

    task automatic test_restart();
        logic [7:0] l0;
        logic [3:0] e;
        int cyc;
        gq.push_back(model[0]);
        l0 = m_lfsr;
        start = 1'b1;
        game_req = 1'b1; game_we = 1'b0; game_addr = 4'd0;
        #1;
        checks++;
        if (game_gnt !== 1'b1) begin
            errors++;
            $display("FAIL restart_gnt: got %b expected 1", game_gnt);
        end
        @(negedge CLOCK_50);
        start = 1'b0; game_req = 1'b0;
        e = gq.pop_front();
        checks++;
        if (game_rvalid !== 1'b1 || game_rdata !== e || init_done !== 1'b0) begin
            errors++;
            $display("FAIL restart_inflight: rvalid %b rdata %h init_done %b expected 1 %h 0",
                     game_rvalid, game_rdata, init_done, e);
        end
        build_model(l0);
        game_req = 1'b1; disp_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({game_gnt, disp_gnt} !== 2'b00) begin
                errors++;
                $display("FAIL fill_no_gnt cycle %0d: got %b%b expected 00", c, game_gnt, disp_gnt);
            end
            @(negedge CLOCK_50);
        end
        game_req = 1'b0; disp_req = 1'b0;
        wait_init(cyc);
        checks++;
        if (cyc != 21) begin
            errors++;
            $display("FAIL restart_latency: got %0d more cycles expected 21", cyc);
        end
        read_all_game("restart_board");
    endtask

    task automatic test_quit_shuffle();
        int cyc;
        start_game();
        repeat (14) @(negedge CLOCK_50);
        userquit = 1'b1;
        @(negedge CLOCK_50);
        userquit = 1'b0;
        checks++;
        if ({init_done, game_gnt, disp_gnt, game_rvalid, disp_rvalid, game_rdata, disp_rdata} !== 13'h0) begin
            errors++;
            $display("FAIL quit_outputs: got %h expected 0",
                     {init_done, game_gnt, disp_gnt, game_rvalid, disp_rvalid, game_rdata, disp_rdata});
        end
        repeat (3) @(negedge CLOCK_50);
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL quit_abandon: init_done %b expected 0", init_done);
        end
        start_game();
        wait_init(cyc);
        checks++;
        if (cyc != 26) begin
            errors++;
            $display("FAIL quit_reinit_latency: got %0d expected 26", cyc);
        end
        read_all_game("quit_board");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_restart();
        test_quit_shuffle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
